// File: rtl/retire_trace_buffer.sv
// Circular trace buffer for retirement check events: arm, trigger, capture a
// post-trigger window, then stream the frozen window oldest-first.
module retire_trace_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int POST_TRIG  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_check_en,
    input  logic [31:0]           i_check_pc,
    input  logic [31:0]           i_check_data,
    input  logic [31:0]           i_check_addr,
    input  logic                  i_arm,
    input  logic                  i_abort,
    input  logic                  i_trig_pc_en,
    input  logic [31:0]           i_trig_pc,
    input  logic                  i_force_trig,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [95:0]           o_rd_data,
    output logic [1:0]            o_state,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_wrapped
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PT   = DEPTH_LOG2'(POST_TRIG);
    localparam logic [DEPTH_LOG2-1:0] ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

    state_t                r_state, w_state_nxt;
    logic [95:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr, r_post;
    logic [DEPTH_LOG2:0]   r_count, r_rem;
    logic                  r_wrapped, r_force;

    logic                  w_wr, w_trig, w_full, w_xfer;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    always_comb begin
        w_wr         = i_check_en && (r_state == S_ARMED || r_state == S_POST);
        w_trig       = i_check_en && (r_state == S_ARMED) &&
                       (r_force || i_force_trig || (i_trig_pc_en && i_check_pc == i_trig_pc));
        w_full       = (r_count == FULL);
        w_wr_ptr_nxt = r_wr_ptr + ONE;
        w_count_nxt  = w_full ? r_count : r_count + 1'b1;
        w_xfer       = (r_state == S_DONE) && i_rd_ready;

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_arm) w_state_nxt = S_ARMED;
            S_ARMED: if (w_trig) w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
            S_POST:  if (i_check_en && r_post == ONE) w_state_nxt = S_DONE;
            S_DONE:  if (w_xfer && r_rem == 1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_post    <= '0;
            r_count   <= '0;
            r_rem     <= '0;
            r_wrapped <= 1'b0;
            r_force   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!i_abort) begin
                if (r_state == S_IDLE && i_arm) begin
                    r_wr_ptr  <= '0;
                    r_count   <= '0;
                    r_wrapped <= 1'b0;
                    r_post    <= '0;
                end
                if (w_wr) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                    r_count  <= w_count_nxt;
                    if (w_full) r_wrapped <= 1'b1;
                end
                if (r_state == S_ARMED) begin
                    if (w_trig) begin
                        r_force <= 1'b0;
                        r_post  <= PT;
                    end else if (i_force_trig) begin
                        r_force <= 1'b1;
                    end
                end
                if (r_state == S_POST && i_check_en) r_post <= r_post - ONE;
                // DONE is always entered on a write edge, so seed readout from the post-write pointers
                if (w_state_nxt == S_DONE && r_state != S_DONE) begin
                    r_rd_ptr <= w_wr_ptr_nxt - w_count_nxt[DEPTH_LOG2-1:0];
                    r_rem    <= w_count_nxt;
                end
                if (w_xfer) begin
                    r_rd_ptr <= r_rd_ptr + ONE;
                    r_rem    <= r_rem - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_abort && w_wr) r_mem[r_wr_ptr] <= {i_check_pc, i_check_data, i_check_addr};
    end

    assign o_rd_valid = (r_state == S_DONE);
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_state    = r_state;
    assign o_count    = r_count;
    assign o_wrapped  = r_wrapped;
endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Trace buffer that sits directly downstream of the retirement probe. It consumes the probe's per-retirement check stream (check_en with pc, store data, store address) and records it into a circular buffer. Capture is armed by software or the bench, stops a fixed number of retirements after a PC-match or forced trigger, and the frozen window is then streamed out oldest-first over a valid/ready port toward the board debug link.

## Interface
- DEPTH_LOG2, 3: buffer holds 2^DEPTH_LOG2 entries (DEPTH).
- POST_TRIG, 2: retirements captured after the trigger entry; legal range 0..DEPTH-1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- check_en  in  1  one retirement event this cycle.
- check_pc / check_data / check_addr  in  32 each  retired pc, store data, store address.
- arm  in  1  pulse: start a capture (honoured only in IDLE).
- abort  in  1  pulse: return to IDLE from any state.
- trig_pc_en  in  1  enable PC-match trigger.
- trig_pc  in  32  trigger PC.
- force_trig  in  1  trigger on the next recorded event regardless of PC.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  96  {pc, data, addr} of the current entry.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count  out  DEPTH_LOG2+1  entries held, saturates at DEPTH.
- wrapped  out  1  at least one entry was overwritten in this capture.

## Operation
- IDLE: check_en ignored. arm (without abort) clears wr_ptr, count, wrapped, post counter; go to ARMED.
- ARMED: each check_en writes the entry at wr_ptr; wr_ptr increments mod DEPTH; count = min(count+1, DEPTH); wrapped is set when a write occurs with count already at DEPTH.
- Trigger: the event is written and trig = check_en && (force_trig_latched || (trig_pc_en && check_pc == trig_pc)). force_trig is latched in ARMED until consumed. On trigger, the event is written, the post counter is loaded with POST_TRIG, and the state goes to POST. With POST_TRIG = 0, the state goes directly to DONE.
- POST: each check_en writes as in ARMED and decrements the post counter. The write that brings it to 0 moves the state to DONE. Triggers are ignored in POST.
- DONE: writes stop and check_en is ignored. The read pointer starts at (wr_ptr - count) mod DEPTH. rd_valid = 1, and rd_data = the entry at the read pointer.
  - On rd_valid && rd_ready: the read pointer increments mod DEPTH and the remaining count decrements.
  - The transfer of the last entry returns the state to IDLE.
  - count holds the captured total throughout readout.
- rd_data is forced to 0 whenever rd_valid = 0.
- abort wins over arm and over every other event on the same edge. It returns to IDLE, clears rd_valid, and discards the remaining readout.
- rst has the same effect as abort and also clears count, wrapped, the latched force_trig, and all pointers. Buffer contents are not cleared and are unobservable.

## Timing
- Reset values: state = 0, rd_valid = 0, rd_data = 0, count = 0, wrapped = 0.
- A write and its state/count update take effect on the same posedge on which check_en is sampled high. There is no input latency.
- state = 3 and rd_valid = 1 in the cycle after the final post-trigger write edge.
- Back-to-back reads: one entry per cycle while rd_ready is held high. With rd_ready low, rd_data is stable.
- Readout of N entries with rd_ready tied high: IDLE is reached N cycles after DONE is entered.
- An arm pulse arriving outside IDLE is dropped, not queued.

## Test plan
- Reset: rst held for 2 cycles mid-ARMED -> state = 0, count = 0, wrapped = 0, rd_valid = 0, rd_data = 0.
- No wrap (DEPTH_LOG2 = 3, POST_TRIG = 2, trig_pc = 0x08):
  - Stimulus: arm, then events pc 0x00, 0x04, 0x08, 0x0C, 0x10 with gaps of 0-3 idle cycles.
  - Response: DONE after 0x10, count = 5, wrapped = 0.
  - Readout with rd_ready high: pc 0x00..0x10 in order, then state = 0.
- Wrap:
  - Stimulus: events pc 0x00..0x2C, step 4, 12 events; trigger at 0x24.
  - Response: DONE after 0x2C, count = 8, wrapped = 1; readout pc 0x10..0x2C in order; data/addr fields match the events sent.
- Backpressure: during the no-wrap readout, rd_ready is random at about 50% -> every entry is transferred exactly once and rd_data is unchanged while rd_valid && !rd_ready.
- Forced trigger / POST_TRIG = 0:
  - Stimulus: force_trig pulse in ARMED with no events, then one event pc 0x40.
  - Response: DONE on that edge, count = 1, readout 0x40.
  - Also: check_en pulses during DONE leave count unchanged.
- Abort:
  - abort during POST -> IDLE next cycle, rd_valid never asserts.
  - arm and abort on the same cycle in IDLE -> state stays 0.
  - arm during ARMED -> ignored, and count continues.
